root_power_arbiter: RTL
=======================

Name: root_power_arbiter

Overview:
Round-robin scheduler that shares the ROOT_NUM twiddle/root-power RAM units among NTT_NUM NTT/INTT engines.
- Accepts per-engine requests naming a target root unit and a burst length.
- Grants each root unit to one engine at a time.
- Drives the interconnect's `ntt_intt_select` (root→engine) and `root_select` (engine→root) buses.
- Holds each route through the interconnect pipeline drain before releasing the unit.

Parameters:
- NTT_NUM, 4, number of NTT/INTT requesters
- ROOT_NUM, 4, number of root-power units
- BURST_W, 12, width of burst-length field (cycles of W/WQ read traffic)
- PIPE_LAT, 2, interconnect select→data latency; grant route held this many extra cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NTT_NUM  engine i requests a root unit
- req_root  in  NTT_NUM x clog2(ROOT_NUM)  target root unit per engine
- req_len  in  NTT_NUM x BURST_W  burst length in cycles; 0 is treated as 1
- req_ready  out  NTT_NUM  request accepted this cycle (combinational)
- ntt_grant_vld  out  NTT_NUM  engine i may issue W/WQ read addresses
- root_select  out  NTT_NUM x clog2(ROOT_NUM)  engine→root routing to the interconnect
- root_busy  out  ROOT_NUM  unit is in GRANT or DRAIN
- ntt_intt_select  out  ROOT_NUM x clog2(NTT_NUM)  root→engine routing to the interconnect
- done_pulse  out  NTT_NUM  one-cycle pulse when engine i's grant fully retires

Behaviour:
- Each root unit r has a registered FSM with three states: IDLE, GRANT, DRAIN. Each unit also has:
  - a BURST_W-bit down-counter
  - a clog2(PIPE_LAT+1)-bit drain counter
  - a round-robin pointer rr[r]
  - an owner register
- Eligibility: engine i is eligible for unit r when all of the following hold:
  - req_valid[i]
  - req_root[i]==r
  - engine i holds no active grant, meaning it is not the owner of any unit in GRANT or DRAIN
- Arbitration (IDLE only): the winner is the first eligible engine scanning rr[r], rr[r]+1, … modulo NTT_NUM.
  - req_ready[winner]=1 in that cycle.
  - All other req_ready are 0.
  - Requests from busy engines are ignored; they stay pending without error.
  - No cross-unit conflict is possible, since each request names exactly one unit.
- Accept at cycle T:
  - T+1: state=GRANT, owner=winner, ntt_intt_select[r]=winner, root_select[winner]=r, ntt_grant_vld[winner]=1, counter=max(len,1)-1, rr[r]=winner+1 (wraps).
- GRANT: the counter decrements each cycle. The unit stays in GRANT for exactly max(len,1) cycles (T+1..T+len).
  - When counter==0: if PIPE_LAT>0, go to DRAIN with drain=PIPE_LAT-1; otherwise go to IDLE.
- DRAIN: ntt_grant_vld[owner]=0, but both select buses are held and root_busy stays 1. The unit lasts PIPE_LAT cycles, then goes to IDLE.
- done_pulse[owner]=1 in the final cycle of GRANT (PIPE_LAT=0) or the final cycle of DRAIN.
  - The same engine is eligible again in the following cycle.
  - The unit can re-accept in its first IDLE cycle, so there is no bubble beyond that IDLE cycle.
- Select buses are registered and hold their last value when not granted. Consumers qualify them with ntt_grant_vld/root_busy.
- ntt_intt_select and root_select change only on an accept edge.
- An engine owns at most one unit; req_valid held high during its own grant has no effect.
- Reset (any cycle, including mid-GRANT/DRAIN), next edge:
  - all FSMs return to IDLE
  - rr=0, counters=0
  - all selects=0
  - ntt_grant_vld=0, root_busy=0, done_pulse=0
  - no done_pulse is issued for aborted grants
- req_ready is 0 while rst=1.
- Maximum len (2^BURST_W-1) is supported without counter overflow.

Test Plan:
- Single request: engine 2 asks root 1, len=3, PIPE_LAT=2.
  - req_ready[2] at T.
  - ntt_grant_vld[2] high T+1..T+3.
  - ntt_intt_select[1]=2 and root_select[2]=1 from T+1.
  - root_busy[1] high T+1..T+5.
  - done_pulse[2] at T+5.
- Contention: engines 0, 1, 3 continuously request root 0, len=1 → grants issued in order 0, 1, 3, 0, …; successive accepts are 4 cycles apart (1 GRANT + 2 DRAIN + 1 IDLE).
- Parallel: engines 0–3 request roots 3, 2, 1, 0 simultaneously.
  - All four req_ready are high in the same cycle.
  - ntt_intt_select={0,1,2,3} for roots 3..0.
- len=0 → behaves as len=1: one GRANT cycle, done_pulse 2 cycles later.
- Reset mid-GRANT (engine 1, root 2, len=10, rst at T+4) → at T+5 all outputs are 0, no done_pulse; a new request is accepted at T+5 with rr reset (engine 0 wins over engine 1 if both request root 2).
- Back-to-back: engine 1 holds req_valid through its own grant → no second accept before done_pulse; re-accept occurs in the first IDLE cycle.

Source files
------------

// File: rtl/root_power_arbiter_if.sv
// Request/grant bundle between NTT/INTT engines and the root-power arbiter,
// including the routing selects handed to the twiddle interconnect.
`timescale 1ns/1ps
interface root_power_arbiter_if #(
  parameter int unsigned NTT_NUM  = 4,
  parameter int unsigned ROOT_NUM = 4,
  parameter int unsigned BURST_W  = 12
);
  localparam int unsigned NW = (NTT_NUM  > 1) ? $clog2(NTT_NUM)  : 1;
  localparam int unsigned RW = (ROOT_NUM > 1) ? $clog2(ROOT_NUM) : 1;

  logic [NTT_NUM-1:0]                req_valid;
  logic [NTT_NUM-1:0][RW-1:0]        req_root;
  logic [NTT_NUM-1:0][BURST_W-1:0]   req_len;
  logic [NTT_NUM-1:0]                req_ready;
  logic [NTT_NUM-1:0]                ntt_grant_vld;
  logic [NTT_NUM-1:0][RW-1:0]        root_select;
  logic [ROOT_NUM-1:0]               root_busy;
  logic [ROOT_NUM-1:0][NW-1:0]       ntt_intt_select;
  logic [NTT_NUM-1:0]                done_pulse;

  modport master (
    output req_valid, req_root, req_len,
    input  req_ready, ntt_grant_vld, root_select, root_busy,
           ntt_intt_select, done_pulse
  );

  modport slave (
    input  req_valid, req_root, req_len,
    output req_ready, ntt_grant_vld, root_select, root_busy,
           ntt_intt_select, done_pulse
  );
endinterface

// File: rtl/root_power_arbiter.sv
// Per-root-unit round-robin arbiter: grants each twiddle RAM unit to one engine
// for a burst, then holds the route through the interconnect pipeline drain.
`timescale 1ns/1ps
module root_power_arbiter #(
  parameter int unsigned NTT_NUM  = 4,
  parameter int unsigned ROOT_NUM = 4,
  parameter int unsigned BURST_W  = 12,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  root_power_arbiter_if.slave bus
);
  localparam int unsigned NW = (NTT_NUM  > 1) ? $clog2(NTT_NUM)  : 1;
  localparam int unsigned RW = (ROOT_NUM > 1) ? $clog2(ROOT_NUM) : 1;
  localparam int unsigned DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = (PIPE_LAT > 0) ? DW'(PIPE_LAT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q [ROOT_NUM];
  state_t             state_d [ROOT_NUM];
  logic [BURST_W-1:0] cnt_q   [ROOT_NUM];
  logic [BURST_W-1:0] cnt_d   [ROOT_NUM];
  logic [DW-1:0]      drain_q [ROOT_NUM];
  logic [DW-1:0]      drain_d [ROOT_NUM];
  logic [NW-1:0]      rr_q    [ROOT_NUM];
  logic [NW-1:0]      rr_d    [ROOT_NUM];
  logic [NW-1:0]      owner_q [ROOT_NUM];
  logic [NW-1:0]      owner_d [ROOT_NUM];
  logic [RW-1:0]      rsel_q  [NTT_NUM];
  logic [RW-1:0]      rsel_d  [NTT_NUM];

  logic [NTT_NUM-1:0]  engine_busy;
  logic [ROOT_NUM-1:0] found;
  logic [ROOT_NUM-1:0] accept;
  logic [ROOT_NUM-1:0] last;
  logic [NW-1:0]       winner  [ROOT_NUM];

  // An engine is busy while any unit it owns is still in GRANT or DRAIN.
  always_comb begin
    engine_busy = '0;
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      for (int unsigned i = 0; i < NTT_NUM; i++) begin
        if (state_q[r] != IDLE && owner_q[r] == NW'(i)) engine_busy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [NW-1:0] cand;
    cand   = '0;
    found  = '0;
    accept = '0;
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      winner[r] = '0;
      for (int unsigned k = 0; k < NTT_NUM; k++) begin
        cand = NW'((32'(rr_q[r]) + k) % NTT_NUM);
        if (!found[r] && !rst && bus.req_valid[cand] &&
            bus.req_root[cand] == RW'(r) && !engine_busy[cand]) begin
          found[r]  = 1'b1;
          winner[r] = cand;
        end
      end
      accept[r] = found[r] && (state_q[r] == IDLE);
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      for (int unsigned i = 0; i < NTT_NUM; i++) begin
        if (accept[r] && winner[r] == NW'(i)) bus.req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      state_d[r] = state_q[r];
      cnt_d[r]   = cnt_q[r];
      drain_d[r] = drain_q[r];
      rr_d[r]    = rr_q[r];
      owner_d[r] = owner_q[r];
      unique case (state_q[r])
        IDLE: begin
          if (accept[r]) begin
            state_d[r] = GRANT;
            owner_d[r] = winner[r];
            cnt_d[r]   = (bus.req_len[winner[r]] == '0) ? '0
                         : bus.req_len[winner[r]] - BURST_W'(1);
            rr_d[r]    = (winner[r] == NW'(NTT_NUM - 1)) ? '0 : winner[r] + NW'(1);
          end
        end
        GRANT: begin
          if (cnt_q[r] == '0) begin
            if (PIPE_LAT > 0) begin
              state_d[r] = DRAIN;
              drain_d[r] = DRAIN_INIT;
            end else begin
              state_d[r] = IDLE;
            end
          end else begin
            cnt_d[r] = cnt_q[r] - BURST_W'(1);
          end
        end
        DRAIN: begin
          if (drain_q[r] == '0) state_d[r] = IDLE;
          else                  drain_d[r] = drain_q[r] - DW'(1);
        end
        default: state_d[r] = IDLE;
      endcase
    end
  end

  // Engine-side route follows whichever unit just accepted that engine.
  always_comb begin
    for (int unsigned i = 0; i < NTT_NUM; i++) begin
      rsel_d[i] = rsel_q[i];
      for (int unsigned r = 0; r < ROOT_NUM; r++) begin
        if (accept[r] && winner[r] == NW'(i)) rsel_d[i] = RW'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROOT_NUM; r++) begin
        state_q[r] <= IDLE;
        cnt_q[r]   <= '0;
        drain_q[r] <= '0;
        rr_q[r]    <= '0;
        owner_q[r] <= '0;
      end
      for (int unsigned i = 0; i < NTT_NUM; i++) rsel_q[i] <= '0;
    end else begin
      for (int unsigned r = 0; r < ROOT_NUM; r++) begin
        state_q[r] <= state_d[r];
        cnt_q[r]   <= cnt_d[r];
        drain_q[r] <= drain_d[r];
        rr_q[r]    <= rr_d[r];
        owner_q[r] <= owner_d[r];
      end
      for (int unsigned i = 0; i < NTT_NUM; i++) rsel_q[i] <= rsel_d[i];
    end
  end

  // The retiring cycle is the last GRANT cycle when there is no drain phase.
  always_comb begin
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      if (PIPE_LAT == 0) last[r] = (state_q[r] == GRANT) && (cnt_q[r] == '0);
      else               last[r] = (state_q[r] == DRAIN) && (drain_q[r] == '0);
    end
  end

  always_comb begin
    bus.ntt_grant_vld = '0;
    bus.done_pulse    = '0;
    for (int unsigned r = 0; r < ROOT_NUM; r++) begin
      bus.root_busy[r]       = (state_q[r] != IDLE);
      bus.ntt_intt_select[r] = owner_q[r];
      for (int unsigned i = 0; i < NTT_NUM; i++) begin
        if (owner_q[r] == NW'(i)) begin
          if (state_q[r] == GRANT) bus.ntt_grant_vld[i] = 1'b1;
          if (last[r] && !rst)     bus.done_pulse[i]    = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NTT_NUM; i++) bus.root_select[i] = rsel_q[i];
  end
endmodule
